// File: rtl/ram_2147_ctl.sv
// Sequencer for a 32-bit wide bank of 4Kx1 static RAMs: it clears every word after reset,
// then runs single host reads and writes through a setup/pulse/hold write-enable sequence.
module ram_2147_ctl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        init_done,
  output logic [11:0] ram_a,
  output logic        ram_ce_n,
  output logic        ram_we_n,
  output logic [31:0] ram_di,
  input  logic [31:0] ram_do
);

  localparam logic [3:0] INIT_SETUP = 4'd0;
  localparam logic [3:0] INIT_PULSE = 4'd1;
  localparam logic [3:0] INIT_HOLD  = 4'd2;
  localparam logic [3:0] IDLE       = 4'd3;
  localparam logic [3:0] RD_CE      = 4'd4;
  localparam logic [3:0] RD_WAIT    = 4'd5;
  localparam logic [3:0] RD_LATCH   = 4'd6;
  localparam logic [3:0] WR_SETUP   = 4'd7;
  localparam logic [3:0] WR_PULSE   = 4'd8;
  localparam logic [3:0] WR_HOLD    = 4'd9;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [3:0]  state;
  logic [11:0] init_cnt;
  logic [3:0]  wait_cnt;

  assign busy = (state != IDLE);

  // Every RAM-side output is a register loaded on the transition into the state that owns it,
  // so the pins change exactly at state boundaries and nothing reaches them combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT_SETUP;
      init_cnt  <= 12'd0;
      wait_cnt  <= 4'd0;
      ack       <= 1'b0;
      rdata     <= 32'd0;
      init_done <= 1'b0;
      ram_a     <= 12'd0;
      ram_ce_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_di    <= 32'd0;
    end else begin
      ack <= 1'b0;
      case (state)
        INIT_SETUP: begin
          ram_ce_n <= 1'b0;
          ram_we_n <= 1'b0;
          state    <= INIT_PULSE;
        end
        INIT_PULSE: begin
          ram_we_n <= 1'b1;
          state    <= INIT_HOLD;
        end
        INIT_HOLD: begin
          if (init_cnt == 12'hFFF) begin
            init_done <= 1'b1;
            ram_ce_n  <= 1'b1;
            state     <= IDLE;
          end else begin
            init_cnt <= init_cnt + 12'd1;
            ram_a    <= init_cnt + 12'd1;
            ram_di   <= 32'd0;
            state    <= INIT_SETUP;
          end
        end
        IDLE: begin
          if (req) begin
            ram_a    <= addr;
            ram_ce_n <= 1'b0;
            if (wr) begin
              ram_di <= wdata;
              state  <= WR_SETUP;
            end else begin
              state <= RD_CE;
            end
          end
        end
        WR_SETUP: begin
          ram_we_n <= 1'b0;
          state    <= WR_PULSE;
        end
        WR_PULSE: begin
          ram_we_n <= 1'b1;
          ack      <= 1'b1;
          state    <= WR_HOLD;
        end
        WR_HOLD: begin
          ram_ce_n <= 1'b1;
          state    <= IDLE;
        end
        RD_CE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          // Sample the parts on the last wait cycle so rdata is valid together with ack.
          if (wait_cnt == 4'd0) begin
            rdata <= ram_do;
            ack   <= 1'b1;
            state <= RD_LATCH;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RD_LATCH: begin
          ram_ce_n <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          ram_ce_n <= 1'b1;
          ram_we_n <= 1'b1;
          state    <= INIT_SETUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_2147_ctl.sv
// Bench for ram_2147_ctl: two instances (WAIT_CYCLES 1 and 3), each with a behavioural SRAM bank,
// a shadow memory for expected data and a scoreboard queue of pending read results.
module tb_ram_2147_ctl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req [2];
  logic        wr [2];
  logic [11:0] addr [2];
  logic [31:0] wdata [2];
  logic        ack [2];
  logic [31:0] rdata [2];
  logic        busy [2];
  logic        init_done [2];
  logic [11:0] ram_a [2];
  logic        ram_ce_n [2];
  logic        ram_we_n [2];
  logic [31:0] ram_di [2];
  wire  [31:0] ram_do0;
  wire  [31:0] ram_do1;

  logic [31:0] mem0 [4096];
  logic [31:0] mem1 [4096];
  logic [31:0] shadow [2][4096];
  bit          filled = 1'b0;

  typedef struct {
    int          d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_2147_ctl #(.WAIT_CYCLES(1)) dut0 (
    .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]), .init_done(init_done[0]),
    .ram_a(ram_a[0]), .ram_ce_n(ram_ce_n[0]), .ram_we_n(ram_we_n[0]), .ram_di(ram_di[0]),
    .ram_do(ram_do0)
  );

  ram_2147_ctl #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]), .init_done(init_done[1]),
    .ram_a(ram_a[1]), .ram_ce_n(ram_ce_n[1]), .ram_we_n(ram_we_n[1]), .ram_di(ram_di[1]),
    .ram_do(ram_do1)
  );

  // SRAM banks start with garbage so the power-up clear is actually observable.
  assign ram_do0 = ram_ce_n[0] ? 32'hzzzzzzzz : mem0[ram_a[0]];
  assign ram_do1 = ram_ce_n[1] ? 32'hzzzzzzzz : mem1[ram_a[1]];

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 4096; i++) begin
        mem0[i] <= $urandom;
        mem1[i] <= $urandom;
      end
      filled <= 1'b1;
    end else begin
      if (!ram_ce_n[0] && !ram_we_n[0]) mem0[ram_a[0]] <= ram_di[0];
      if (!ram_ce_n[1] && !ram_we_n[1]) mem1[ram_a[1]] <= ram_di[1];
    end
  end

  // Write-enable guard: address stable the cycle before and the cycle after a low we_n, ce_n low.
  logic [11:0] prev_a [2];
  logic        prev_we [2];
  initial begin
    prev_a[0] = 12'd0;  prev_a[1] = 12'd0;
    prev_we[0] = 1'b1;  prev_we[1] = 1'b1;
  end
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset && ram_we_n[d] === 1'b0) begin
        checks++;
        if (ram_ce_n[d] !== 1'b0 || ram_a[d] !== prev_a[d]) begin
          errors++;
          $display("FAIL we_guard_setup dut%0d: ce_n=%b a=%h prev_a=%h, need ce_n=0 and stable a",
                   d, ram_ce_n[d], ram_a[d], prev_a[d]);
        end
      end
      if (!reset && prev_we[d] === 1'b0) begin
        checks++;
        if (ram_a[d] !== prev_a[d]) begin
          errors++;
          $display("FAIL we_guard_hold dut%0d: a=%h, required %h", d, ram_a[d], prev_a[d]);
        end
      end
      prev_a[d]  = ram_a[d];
      prev_we[d] = ram_we_n[d];
    end
  end

  task automatic clear_shadow();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4096; i++) shadow[d][i] = 32'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ram_ce_n[d] !== 1'b1 || ram_we_n[d] !== 1'b1 || ack[d] !== 1'b0 || busy[d] !== 1'b1 ||
          init_done[d] !== 1'b0 || rdata[d] !== 32'd0 || ram_a[d] !== 12'd0 || ram_di[d] !== 32'd0) begin
        errors++;
        $display("FAIL %s dut%0d: ce_n=%b we_n=%b ack=%b busy=%b init_done=%b rdata=%h a=%h di=%h, required 1 1 0 1 0 0 0 0",
                 tag, d, ram_ce_n[d], ram_we_n[d], ack[d], busy[d], init_done[d], rdata[d], ram_a[d], ram_di[d]);
      end
    end
  endtask

  // Releases reset and counts cycles until init_done; optionally keeps a read of 0x010 pending on dut1.
  task automatic wait_init(input bit pend);
    int  n;
    int  m;
    bit  early;
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    if (pend) begin
      req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 12'h010;
      exp_q.push_back('{d: 1, data: shadow[1][12'h010]});
    end
    n = 0; early = 1'b0;
    while (init_done[0] !== 1'b1 && n < 13000) begin
      @(posedge clk); #1;
      n++;
      if (ack[0] === 1'b1 || ack[1] === 1'b1) early = 1'b1;
    end
    checks++;
    if (n != 12288) begin
      errors++;
      $display("FAIL init_length: init_done after %0d cycles, required 12288", n);
    end
    checks++;
    if (init_done[1] !== 1'b1) begin
      errors++;
      $display("FAIL init_done_w3: init_done=%b, required 1", init_done[1]);
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL ack_during_init: ack seen before init_done, required none");
    end
    checks++;
    if (rdata[0] !== 32'd0) begin
      errors++;
      $display("FAIL rdata_after_init: rdata=%h, required 00000000", rdata[0]);
    end
    if (pend) begin
      m = 0;
      while (ack[1] !== 1'b1 && m < 40) begin
        @(posedge clk); #1;
        m++;
      end
      req[1] = 1'b0;
      checks++;
      if (m != 5) begin
        errors++;
        $display("FAIL pending_read_latency: ack %0d cycles after first IDLE, required 5", m);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rdata[e.d] !== e.data) begin
          errors++;
          $display("FAIL pending_read_data: rdata=%h, required %h", rdata[e.d], e.data);
        end
      end
      @(posedge clk); #1;
    end
    $display("init: done after %0d cycles", n);
  endtask

  // One host access; starts at #1 after an edge with the instance in IDLE and ends in the next IDLE cycle.
  task automatic access(input int d, input bit w, input logic [11:0] a, input logic [31:0] wd);
    int          lat;
    int          n;
    int          we_lows;
    int          ce_lows;
    int          a_bad;
    bit          got;
    bit          busy_bad;
    logic [31:0] old_rdata;
    exp_t        e;
    lat = w ? 3 : (2 + ((d == 0) ? 1 : 3));
    old_rdata = rdata[d];
    if (w) shadow[d][a] = wd;
    else   exp_q.push_back('{d: d, data: shadow[d][a]});
    req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
    n = 0; we_lows = 0; ce_lows = 0; a_bad = 0; got = 1'b0; busy_bad = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (ram_we_n[d] === 1'b0) we_lows++;
      if (ram_ce_n[d] === 1'b0) ce_lows++;
      if (ram_a[d] !== a || (w && ram_di[d] !== wd)) a_bad++;
      if (busy[d] !== 1'b1) busy_bad = 1'b1;
      if (ack[d] === 1'b1) got = 1'b1;
    end
    req[d] = 1'b0;
    checks++;
    if (!got || n != lat) begin
      errors++;
      $display("FAIL %s_latency dut%0d a=%h: ack after %0d cycles, required %0d", w ? "wr" : "rd", d, a, n, lat);
    end
    checks++;
    if (we_lows != (w ? 1 : 0) || ce_lows != lat || a_bad != 0 || busy_bad) begin
      errors++;
      $display("FAIL %s_pins dut%0d: we_low=%0d ce_low=%0d addr_bad=%0d busy_bad=%0b, required %0d %0d 0 0",
               w ? "wr" : "rd", d, we_lows, ce_lows, a_bad, busy_bad, w ? 1 : 0, lat);
    end
    if (w) begin
      checks++;
      if (rdata[d] !== old_rdata) begin
        errors++;
        $display("FAIL rdata_kept_on_write dut%0d: rdata=%h, required %h", d, rdata[d], old_rdata);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[e.d] !== e.data) begin
        errors++;
        $display("FAIL rd_data dut%0d a=%h: rdata=%h, required %h", d, a, rdata[e.d], e.data);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (ack[d] !== 1'b0 || busy[d] !== 1'b0 || ram_ce_n[d] !== 1'b1) begin
      errors++;
      $display("FAIL back_to_idle dut%0d: ack=%b busy=%b ce_n=%b, required 0 0 1", d, ack[d], busy[d], ram_ce_n[d]);
    end
    $display("access dut%0d %s a=%h wd=%h rdata=%h lat=%0d", d, w ? "WR" : "RD", a, wd, rdata[d], n);
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset_state");
    $display("reset: outputs checked");
  endtask

  task automatic test_init_pending();
    clear_shadow();
    wait_init(1'b1);
  endtask

  task automatic test_read_top();
    access(0, 1'b0, 12'hFFF, 32'd0);
  endtask

  task automatic test_write_read();
    access(0, 1'b1, 12'h123, 32'hDEADBEEF);
    access(0, 1'b0, 12'h123, 32'd0);
  endtask

  task automatic test_patterns();
    logic [11:0] a;
    access(0, 1'b1, 12'h000, 32'hA5A5_5A5A);
    access(0, 1'b1, 12'hFFF, 32'hFFFF_FFFF);
    access(0, 1'b0, 12'h000, 32'd0);
    access(0, 1'b0, 12'hFFF, 32'd0);
    for (int i = 0; i < 4; i++) begin
      a = 12'($urandom);
      access(0, 1'b1, a, $urandom);
      access(0, 1'b0, a, 32'd0);
    end
  endtask

  task automatic test_back_to_back();
    access(1, 1'b1, 12'h001, 32'h1111_0001);
    access(1, 1'b1, 12'h002, 32'h2222_0002);
    access(1, 1'b0, 12'h001, 32'd0);
    access(1, 1'b0, 12'h002, 32'd0);
  endtask

  task automatic test_reset_mid_write();
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 12'h200; wdata[0] = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (ram_we_n[0] !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse_reached: we_n=%b, required 0", ram_we_n[0]);
    end
    reset = 1'b1;
    req[0] = 1'b0;
    #1;
    check_reset_outputs("async_reset_mid_write");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ack[0] !== 1'b0) begin
        errors++;
        $display("FAIL ack_after_abort: ack=%b, required 0", ack[0]);
      end
    end
    clear_shadow();
    wait_init(1'b0);
    access(0, 1'b0, 12'h200, 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; wr[d] = 1'b0; addr[d] = 12'd0; wdata[d] = 32'd0;
    end
    test_reset();
    test_init_pending();
    test_read_top();
    test_write_read();
    test_patterns();
    test_back_to_back();
    test_reset_mid_write();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_2147_ctl.md
RAM_2147_CTL -- requirements
Module: ram_2147_ctl

Interface
REQ-001 SHALL have parameter: WAIT_CYCLES, default 1, number of RD_WAIT cycles (range 1..15) between chip-enable and data capture on reads.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: ports clk and reset, as the codebase names them.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 req  input  1  host request, level; held until ack.
REQ-006 wr  input  1  1 = write, 0 = read; sampled on acceptance.
REQ-007 addr  input  12  word address; sampled on acceptance.
REQ-008 wdata  input  32  write data; sampled on acceptance.
REQ-009 ack  output  1  one-cycle completion strobe.
REQ-010 rdata  output  32  read data, valid in ack cycle of a read, held until the next read ack.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 init_done  output  1  high once the power-up clear completes.
REQ-013 ram_a  output  12  address to the bank of 32 4Kx1 SRAM parts.
REQ-014 ram_ce_n  output  1  chip enable, active low.
REQ-015 ram_we_n  output  1  write enable, active low.
REQ-016 ram_di  output  32  data to the SRAM parts.
REQ-017 ram_do  input  32  data from the SRAM parts; high-Z when ram_ce_n=1.

Function
REQ-018 States: INIT_SETUP, INIT_PULSE, INIT_HOLD, IDLE, RD_CE, RD_WAIT, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-019 All RAM-side outputs and ack SHALL be registered; no combinational path from req to any output.
REQ-020 Init: a 12-bit counter starts at 0; for each word, INIT_SETUP -> INIT_PULSE -> INIT_HOLD, with ram_di=0 and ram_a=counter.
REQ-021 After INIT_HOLD at counter 0xFFF, go to IDLE and set init_done=1; otherwise increment the counter and return to INIT_SETUP. Init lasts exactly 12288 cycles.
REQ-022 req SHALL be ignored (no ack, no capture) until IDLE is reached; a req pending during init is accepted in the first IDLE cycle.
REQ-023 Acceptance: in IDLE with req=1 (cycle T), capture addr/wr/wdata and go to RD_CE or WR_SETUP.
REQ-024 Write timing: ram_a/ram_di stable from T+1 through T+3; ram_ce_n=0 in T+1..T+3; ram_we_n=0 only in T+2 (WR_PULSE); ack=1 in T+3 (WR_HOLD).
REQ-025 Read timing: ram_ce_n=0 and ram_a stable from T+1 through T+2+WAIT_CYCLES; ram_we_n=1 throughout; ram_do captured into rdata and ack=1 in T+2+WAIT_CYCLES (RD_LATCH).
REQ-026 After an ack cycle, return to IDLE; ram_ce_n=1 in IDLE. A req still high in the IDLE cycle after ack is treated as a new request, so the host SHALL drop req in the cycle after ack.
REQ-027 ram_we_n SHALL never be low unless ram_ce_n is low, ram_a has been stable for at least one cycle, and ram_a stays stable for one cycle after.
REQ-028 Address wraps naturally at 12 bits; no out-of-range case exists.
REQ-029 rdata SHALL be unchanged by writes and by init.

Reset
REQ-030 On reset assertion, immediately: ram_ce_n=1, ram_we_n=1, ack=0, busy=1, init_done=0, rdata=0, ram_a=0, ram_di=0, init counter=0, state=INIT_SETUP.
REQ-031 Reset mid-write or mid-read SHALL abort the access without an ack; init restarts from address 0 when reset is released.

Verification
REQ-032 Release reset, hold req=0 -> init_done rises exactly 12288 cycles later; a following read of 0xFFF returns 0x00000000.
REQ-033 Write 0xDEADBEEF to 0x123, then read 0x123 with WAIT_CYCLES=1 -> write ack at T+3, read ack at T+3, rdata=0xDEADBEEF; ram_we_n low for exactly 1 cycle.
REQ-034 Assert req (read 0x010) during init -> no ack before init_done; accepted in the first IDLE cycle; returns 0.
REQ-035 Assert reset during WR_PULSE of a write of 0x12345678 to 0x200 -> ram_we_n=1 and ram_ce_n=1 the same instant, no ack, init reruns, then a read of 0x200 returns 0.
REQ-036 WAIT_CYCLES=3, back-to-back reads of 0x001 then 0x002 (req dropped one cycle after each ack) -> each ack at T+5, correct data, exactly one IDLE cycle between the two accesses.
